ts_gen_multi: RTL and testbench

- Synthesizable multi-channel MPEG-TS packet generator; successor to the bench-only single-PID serial TS source used for ts_proxy bring-up.
- Emits 188-byte packets round-robin over up to MAX_CH PIDs, each channel with its own continuity counter and payload pattern.
- Output is a valid/ready byte stream feeding ts_proxy's TSGEN input mux; an optional serializer emulates a demod serial TS port.

---
 rtl/ts_gen_multi.sv | 142 ++++++++++++++
 tb/tb_ts_gen_multi.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_gen_multi.sv
// ts_gen_multi: round-robin multi-PID MPEG-TS packet generator with valid/ready byte output.
// Defining TS_GEN_SERIAL_EN adds a serial TS port (ser_*), which then paces the byte stream instead of out_ready.
module ts_gen_multi #(
  parameter int MAX_CH = 4,
  parameter logic [7:0] PATTERN_INIT = 8'h45
`ifdef TS_GEN_SERIAL_EN
  , parameter int SER_DIV = 2
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [$clog2(MAX_CH):0]  num_ch,
  input  logic [12:0]              pid_base,
  input  logic                     mode,
  input  logic [7:0]               gap,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  output logic                     out_start,
  input  logic                     out_ready,
  output logic [31:0]              pkt_count
`ifdef TS_GEN_SERIAL_EN
  , output logic                   ser_clk,
  output logic                     ser_data,
  output logic                     ser_valid,
  output logic                     ser_start
`endif
);
  localparam int CW = $clog2(MAX_CH) + 1;
  localparam int IW = MAX_CH > 1 ? $clog2(MAX_CH) : 1;
  typedef enum logic [2:0] {IDLE, SYNC, HDR1, HDR2, HDR3, PAYLOAD, GAP} state_t;
  state_t state, state_nx;
  logic [IW-1:0] ch, ch_src, ch_nx;
  logic [CW-1:0] nch_l, ne, nxt;
  logic [3:0] cc [2**IW];
  logic [7:0] pat [2**IW];
  logic [12:0] pid_l, pid;
  logic mode_l, rdy, last, relatch;
  logic [7:0] n, gcnt;

  assign ne = num_ch == '0 ? CW'(1) : (num_ch > CW'(MAX_CH) ? CW'(MAX_CH) : num_ch);
  assign pid = pid_l + 13'(ch);
  assign out_valid = state inside {SYNC, HDR1, HDR2, HDR3, PAYLOAD};
  assign out_start = state == SYNC;
  assign out_data = state == SYNC ? 8'h47 :
                    state == HDR1 ? {3'b000, pid[12:8]} :
                    state == HDR2 ? pid[7:0] :
                    state == HDR3 ? {4'b0001, cc[ch]} :
                    state == PAYLOAD ? pat[ch] + (mode_l ? n : 8'd0) : 8'd0;
  assign last = state == PAYLOAD && n == 8'd183 && rdy;
  assign relatch = enable && (state == IDLE || (state == GAP && gcnt == 8'd1) || (last && gap == 8'd0));
  assign nxt = CW'(ch) + CW'(1);
  // Round-robin advance, then re-clamp against a freshly latched (possibly smaller) channel count.
  assign ch_src = last ? (nxt >= nch_l ? '0 : IW'(nxt)) : ch;
  assign ch_nx = relatch && CW'(ch_src) >= ne ? '0 : ch_src;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = enable ? SYNC : IDLE;
      SYNC:    state_nx = rdy ? HDR1 : SYNC;
      HDR1:    state_nx = rdy ? HDR2 : HDR1;
      HDR2:    state_nx = rdy ? HDR3 : HDR2;
      HDR3:    state_nx = rdy ? PAYLOAD : HDR3;
      PAYLOAD: state_nx = !last ? PAYLOAD : gap != 8'd0 ? GAP : enable ? SYNC : IDLE;
      GAP:     state_nx = gcnt != 8'd1 ? GAP : enable ? SYNC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ch <= '0;
      nch_l <= CW'(1);
      pid_l <= '0;
      mode_l <= 1'b0;
      n <= '0;
      gcnt <= '0;
      pkt_count <= '0;
      for (int i = 0; i < 2**IW; i++) begin
        cc[i] <= '0;
        pat[i] <= PATTERN_INIT;
      end
    end else begin
      state <= state_nx;
      ch <= ch_nx;
      n <= state == PAYLOAD ? n + 8'(rdy) : 8'd0;
      gcnt <= last ? gap : gcnt - 8'(state == GAP);
      if (relatch) begin
        nch_l <= ne;
        pid_l <= pid_base;
        mode_l <= mode;
      end
      if (last) begin
        cc[ch] <= cc[ch] + 4'd1;
        pat[ch] <= pat[ch] + 8'd1;
        pkt_count <= pkt_count + 32'd1;
      end
    end
  end

`ifdef TS_GEN_SERIAL_EN
  localparam int DW = $clog2(2 * SER_DIV) > 0 ? $clog2(2 * SER_DIV) : 1;
  logic [DW-1:0] div;
  logic [7:0] sh;
  logic [2:0] bcnt;
  logic busy, st, bend, ser_rdy;
  assign bend = div == DW'(2 * SER_DIV - 1);
  assign ser_rdy = bend && (!busy || bcnt == 3'd7);
  assign rdy = ser_rdy;
  assign ser_clk = div >= DW'(SER_DIV);
  assign ser_data = sh[7];
  assign ser_valid = busy;
  assign ser_start = busy && st;
  // Shifting only at the end of a bit period keeps ser_data changes inside the ser_clk low phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
      sh <= '0;
      bcnt <= '0;
      busy <= 1'b0;
      st <= 1'b0;
    end else begin
      div <= bend ? '0 : div + DW'(1);
      if (bend) begin
        if (busy && bcnt != 3'd7) begin
          sh <= {sh[6:0], 1'b0};
          bcnt <= bcnt + 3'd1;
        end else begin
          sh <= out_valid ? out_data : 8'd0;
          st <= out_valid && out_start;
          busy <= out_valid;
          bcnt <= '0;
        end
      end
    end
  end
`else
  assign rdy = out_ready;
`endif
endmodule

// File: tb/tb_ts_gen_multi.sv
// tb_ts_gen_multi: directed-vector bench for ts_gen_multi; build with TS_GEN_SERIAL_EN to exercise the serial port.
module tb_ts_gen_multi;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, mode = 1'b0, out_ready = 1'b1;
  logic [2:0] num_ch = 3'd1;
  logic [12:0] pid_base = '0;
  logic [7:0] gap = '0, out_data;
  logic out_valid, out_start;
  logic [31:0] pkt_count;
  int vectors = 0, errors = 0;
  bit rnd = 1'b0, dead = 1'b0;
`ifdef TS_GEN_SERIAL_EN
  logic ser_clk, ser_data, ser_valid, ser_start;
`endif

  ts_gen_multi dut (
    .clk(clk), .reset(reset), .enable(enable), .num_ch(num_ch), .pid_base(pid_base),
    .mode(mode), .gap(gap), .out_data(out_data), .out_valid(out_valid),
    .out_start(out_start), .out_ready(out_ready), .pkt_count(pkt_count)
`ifdef TS_GEN_SERIAL_EN
    , .ser_clk(ser_clk), .ser_data(ser_data), .ser_valid(ser_valid), .ser_start(ser_start)
`endif
  );

  always #5 clk = ~clk;

  task automatic do_reset(input logic [2:0] nc, input logic [12:0] pb, input logic md, input logic [7:0] g);
    reset = 1'b1;
    enable = 1'b1;
    num_ch = nc;
    pid_base = pb;
    mode = md;
    gap = g;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits for the next accepted byte; idl counts cycles with out_valid low before it.
  task automatic next_beat(output logic [7:0] d, output logic s, output int idl);
    logic [7:0] hold;
    logic held;
    held = 1'b0;
    idl = 0;
    d = 'x;
    s = 'x;
    if (dead) return;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rnd) out_ready = $urandom_range(0, 3) != 0;
      if (!out_valid) idl++;
      else begin
        if (held) begin
          vectors++;
          if (out_data !== hold) begin
            errors++;
            $display("FAIL stall_stable: data %h, required %h", out_data, hold);
          end
        end
        hold = out_data;
        held = 1'b1;
        if (out_ready) begin
          d = out_data;
          s = out_start;
          return;
        end
      end
    end
    vectors++;
    errors++;
    dead = 1'b1;
    $display("FAIL beat_timeout: no byte accepted within 300 cycles");
  endtask

  task automatic check_pkt(input logic [12:0] pid, input logic [3:0] cc, input logic [7:0] pat,
                           input logic md, input int drop_at, output int idle0, output logic [7:0] lastb);
    logic [7:0] exp [188];
    logic [7:0] got [188];
    logic s;
    int idl, sbad, vgap, bad;
    exp[0] = 8'h47;
    exp[1] = {3'b000, pid[12:8]};
    exp[2] = pid[7:0];
    exp[3] = {4'b0001, cc};
    for (int k = 0; k < 184; k++) exp[4+k] = pat + (md ? 8'(k) : 8'd0);
    sbad = 0;
    vgap = 0;
    idle0 = 0;
    for (int i = 0; i < 188; i++) begin
      next_beat(got[i], s, idl);
      if (i == 0) idle0 = idl;
      else vgap += idl;
      if (s !== (i == 0)) sbad++;
      if (i == drop_at) enable = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL hdr%0d pid %h: got %h, required %h", i, pid, got[i], exp[i]);
      end
    end
    bad = -1;
    for (int i = 187; i >= 4; i--) if (got[i] !== exp[i]) bad = i;
    vectors++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL payload pid %h byte %0d: got %h, required %h", pid, bad - 4, got[bad], exp[bad]);
    end
    vectors++;
    if (sbad != 0) begin
      errors++;
      $display("FAIL out_start pid %h: %0d wrong beats, required 0", pid, sbad);
    end
    vectors++;
    if (vgap != 0) begin
      errors++;
      $display("FAIL valid_drop pid %h: %0d idle cycles mid-packet, required 0", pid, vgap);
    end
    lastb = got[187];
  endtask

  task automatic test_reset;
    reset = 1'b1;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    vectors += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
    if (out_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b, required 0", out_start); end
    if (out_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h, required 00", out_data); end
    if (pkt_count !== 32'd0) begin errors++; $display("FAIL rst_count: got %0d, required 0", pkt_count); end
  endtask

  task automatic test_basic;
    int idl;
    logic [7:0] lb;
    do_reset(3'd1, 13'h1FE, 1'b0, 8'd0);
    check_pkt(13'h1FE, 4'd0, 8'h45, 1'b0, -1, idl, lb);
    vectors++;
    if (idl != 0) begin errors++; $display("FAIL sync_latency: %0d idle cycles, required 0", idl); end
    check_pkt(13'h1FE, 4'd1, 8'h46, 1'b0, -1, idl, lb);
    vectors++;
    if (idl != 0) begin errors++; $display("FAIL b2b_gap: %0d idle cycles, required 0", idl); end
    @(negedge clk);
    vectors++;
    if (pkt_count !== 32'd2) begin errors++; $display("FAIL pkt_count: got %0d, required 2", pkt_count); end
  endtask

  task automatic test_multi_ch;
    int idl;
    logic [7:0] lb;
    do_reset(3'd3, 13'h1FFF, 1'b0, 8'd0);
    for (int p = 0; p < 49; p++)
      check_pkt(13'h1FFF + 13'(p % 3), 4'(p / 3), 8'h45 + 8'(p / 3), 1'b0, -1, idl, lb);
  endtask

  task automatic test_clamp;
    int idl;
    logic [7:0] lb;
    do_reset(3'd7, 13'h0000, 1'b0, 8'd0);
    for (int p = 0; p < 5; p++)
      check_pkt(13'(p % 4), 4'(p / 4), 8'h45 + 8'(p / 4), 1'b0, -1, idl, lb);
  endtask

  task automatic test_stall;
    int idl;
    logic [7:0] lb;
    do_reset(3'd2, 13'h100, 1'b1, 8'd0);
    rnd = 1'b1;
    check_pkt(13'h100, 4'd0, 8'h45, 1'b1, -1, idl, lb);
    check_pkt(13'h101, 4'd0, 8'h45, 1'b1, -1, idl, lb);
    check_pkt(13'h100, 4'd1, 8'h46, 1'b1, -1, idl, lb);
    rnd = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_gap_stop;
    int idl, vcnt;
    logic [7:0] lb;
    do_reset(3'd1, 13'h020, 1'b0, 8'd5);
    check_pkt(13'h020, 4'd0, 8'h45, 1'b0, -1, idl, lb);
    check_pkt(13'h020, 4'd1, 8'h46, 1'b0, -1, idl, lb);
    vectors++;
    if (idl != 5) begin errors++; $display("FAIL gap1: %0d idle cycles, required 5", idl); end
    check_pkt(13'h020, 4'd2, 8'h47, 1'b0, 104, idl, lb);
    vectors++;
    if (idl != 5) begin errors++; $display("FAIL gap2: %0d idle cycles, required 5", idl); end
    vcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0) vcnt++;
    end
    vectors += 2;
    if (vcnt != 0) begin errors++; $display("FAIL stop_idle: %0d valid cycles, required 0", vcnt); end
    if (pkt_count !== 32'd3) begin errors++; $display("FAIL stop_count: got %0d, required 3", pkt_count); end
  endtask

  task automatic test_mid_reset;
    int idl;
    logic [7:0] lb, d;
    logic s;
    do_reset(3'd1, 13'h055, 1'b0, 8'd0);
    check_pkt(13'h055, 4'd0, 8'h45, 1'b0, -1, idl, lb);
    repeat (50) next_beat(d, s, idl);
    reset = 1'b1;
    @(negedge clk);
    vectors += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b, required 0", out_valid); end
    if (out_data !== 8'h00) begin errors++; $display("FAIL mrst_data: got %h, required 00", out_data); end
    if (pkt_count !== 32'd0) begin errors++; $display("FAIL mrst_count: got %0d, required 0", pkt_count); end
    reset = 1'b0;
    check_pkt(13'h055, 4'd0, 8'h45, 1'b0, -1, idl, lb);
  endtask

  task automatic test_incr;
    int idl;
    logic [7:0] lb;
    do_reset(3'd0, 13'h0ABC, 1'b1, 8'd0);
    for (int k = 0; k < 186; k++)
      check_pkt(13'h0ABC, 4'(k), 8'h45 + 8'(k), 1'b1, -1, idl, lb);
    vectors++;
    if (lb !== 8'h00 + 8'h45 + 8'd185 + 8'd183) begin end
    if (lb !== 8'hB5) begin errors++; $display("FAIL incr_last: got %h, required B5", lb); end
  endtask

`ifdef TS_GEN_SERIAL_EN
  task automatic test_serial;
    logic prev;
    logic [15:0] bits, sst;
    int got, last_rise, per_bad, found;
    do_reset(3'd1, 13'h1FE, 1'b0, 8'd0);
    prev = 1'b0;
    got = 0;
    per_bad = 0;
    last_rise = 0;
    bits = '0;
    sst = '0;
    for (int c = 0; c < 400 && got < 16; c++) begin
      @(negedge clk);
      if (ser_clk && !prev && ser_valid) begin
        bits = {bits[14:0], ser_data};
        sst = {sst[14:0], ser_start};
        if (got > 0 && c - last_rise != 4) per_bad++;
        last_rise = c;
        got++;
      end
      prev = ser_clk;
    end
    vectors += 5;
    if (got != 16) begin errors++; $display("FAIL ser_bits: got %0d bits, required 16", got); end
    if (bits[15:8] !== 8'h47) begin errors++; $display("FAIL ser_sync: got %h, required 47", bits[15:8]); end
    if (bits[7:0] !== 8'h01) begin errors++; $display("FAIL ser_hdr1: got %h, required 01", bits[7:0]); end
    if (sst !== 16'hFF00) begin errors++; $display("FAIL ser_start: got %h, required ff00", sst); end
    if (per_bad != 0) begin errors++; $display("FAIL ser_period: %0d bad periods, required 0", per_bad); end
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      @(negedge clk);
      if (ser_clk && ser_data && ser_valid) found = 1;
    end
    reset = 1'b1;
    @(negedge clk);
    vectors += 2;
    if (found == 0) begin errors++; $display("FAIL ser_midbit: no high bit seen, required one"); end
    if ({ser_clk, ser_data, ser_valid, ser_start} !== 4'b0000) begin
      errors++;
      $display("FAIL ser_reset: got %b, required 0000", {ser_clk, ser_data, ser_valid, ser_start});
    end
    reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
`ifdef TS_GEN_SERIAL_EN
    test_serial;
`else
    test_basic;
    test_multi_ch;
    test_clamp;
    test_stall;
    test_gap_stop;
    test_mid_reset;
    test_incr;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
